// File: rtl/q_cycle_sequencer.sv
// Four-phase (Q1..Q4) instruction-cycle sequencer with forced-NOP startup/flush, sleep/wake and hold.
// Strobes decode combinationally from registered phase/state; hold freezes all state and zeroes every strobe.
module q_cycle_sequencer #(
   parameter int STARTUP_NOPS = 1,
   parameter int INSTR_CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   hold,
   input  logic                   branch_taken,
   input  logic                   sleep_req,
   input  logic                   wake,
   output logic [1:0]             q_phase,
   output logic                   decode_en,
   output logic                   data_rd_en,
   output logic                   exec_en,
   output logic                   wr_en,
   output logic                   instr_rd_en,
   output logic                   incr_pc_en,
   output logic                   pc_load_en,
   output logic                   nop_force,
   output logic                   sleeping,
   output logic [INSTR_CNT_W-1:0] instr_count
);

   typedef enum logic [1:0] {
      ST_STARTUP = 2'd0,
      ST_RUN     = 2'd1,
      ST_FLUSH   = 2'd2,
      ST_SLEEP   = 2'd3
   } state_t;

   localparam logic [1:0] LP_NOPS = 2'(STARTUP_NOPS);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [1:0]             r_phase;
   logic [1:0]             w_phase_nxt;
   logic [1:0]             r_nop_cnt;
   logic [1:0]             w_nop_nxt;
   logic [1:0]             w_nop_inc;
   logic [INSTR_CNT_W-1:0] r_instr_count;
   logic [INSTR_CNT_W-1:0] w_cnt_nxt;

   logic w_q4;
   logic w_act;
   logic w_decode;
   logic w_data_rd;
   logic w_exec;
   logic w_wr;
   logic w_instr_rd;
   logic w_incr_pc;
   logic w_pc_load;
   logic w_nop_force;
   logic w_sleeping;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= ST_STARTUP;
         r_phase       <= 2'd0;
         r_nop_cnt     <= 2'd0;
         r_instr_count <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_phase       <= w_phase_nxt;
         r_nop_cnt     <= w_nop_nxt;
         r_instr_count <= w_cnt_nxt;
      end
   end

   assign w_q4      = (r_phase == 2'd3);
   assign w_nop_inc = r_nop_cnt + 2'd1;

   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_nop_nxt   = r_nop_cnt;
      w_cnt_nxt   = r_instr_count;
      if (!hold) begin
         if (r_state == ST_SLEEP) begin
            w_phase_nxt = 2'd0;
            if (wake) begin
               w_state_nxt = ST_RUN;
            end
         end else begin
            w_phase_nxt = r_phase + 2'd1;
            if (w_q4) begin
               case (r_state)
                  ST_STARTUP: begin
                     w_nop_nxt = w_nop_inc;
                     if (w_nop_inc == LP_NOPS) begin
                        w_state_nxt = ST_RUN;
                     end
                  end
                  ST_RUN: begin
                     w_cnt_nxt = r_instr_count + 1'b1;
                     // branch redirect outranks a concurrent sleep request
                     if (branch_taken) begin
                        w_state_nxt = ST_FLUSH;
                     end else if (sleep_req) begin
                        w_state_nxt = ST_SLEEP;
                     end
                  end
                  ST_FLUSH: begin
                     w_state_nxt = sleep_req ? ST_SLEEP : ST_RUN;
                  end
                  default: begin
                     w_state_nxt = r_state;
                  end
               endcase
            end
         end
      end
   end

   assign w_act = rst_n & ~hold;

   always_comb begin
      w_decode    = 1'b0;
      w_data_rd   = 1'b0;
      w_exec      = 1'b0;
      w_wr        = 1'b0;
      w_instr_rd  = 1'b0;
      w_incr_pc   = 1'b0;
      w_pc_load   = 1'b0;
      w_nop_force = 1'b0;
      w_sleeping  = 1'b0;
      case (r_state)
         ST_RUN: begin
            w_decode   = (r_phase == 2'd0);
            w_data_rd  = (r_phase == 2'd1);
            w_exec     = (r_phase == 2'd2);
            w_wr       = w_q4;
            w_instr_rd = w_q4;
            w_incr_pc  = w_q4 & ~branch_taken;
            w_pc_load  = w_q4 & branch_taken;
         end
         ST_STARTUP, ST_FLUSH: begin
            w_nop_force = 1'b1;
            w_instr_rd  = w_q4;
            w_incr_pc   = w_q4;
         end
         default: begin
            w_sleeping = 1'b1;
         end
      endcase
   end

   assign q_phase     = r_phase;
   assign decode_en   = w_decode   & w_act;
   assign data_rd_en  = w_data_rd  & w_act;
   assign exec_en     = w_exec     & w_act;
   assign wr_en       = w_wr       & w_act;
   assign instr_rd_en = w_instr_rd & w_act;
   assign incr_pc_en  = w_incr_pc  & w_act;
   assign pc_load_en  = w_pc_load  & w_act;
   assign nop_force   = w_nop_force;
   assign sleeping    = w_sleeping;
   assign instr_count = r_instr_count;

endmodule

// File: doc/q_cycle_sequencer.md
Name: q_cycle_sequencer

Overview:
- Generates the four-phase (Q1..Q4) instruction-cycle timing for the PIC16 core.
- Drives the per-phase strobes consumed by instruction_decoder, the ALU, the W/file registers and the PC: decode, read, execute, write, fetch, increment.
- Inserts forced-NOP cycles after reset and after taken branches, so a branch costs 8 clocks. Handles sleep/wake and an external hold.

Parameters:
- STARTUP_NOPS, 1: number of forced-NOP instruction cycles after reset release (range 1..3).
- INSTR_CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- hold  input  1  freezes the sequencer; all strobes forced 0 while high.
- branch_taken  input  1  from decoder/ALU; current instruction redirects the PC (goto/call/return/skip).
- sleep_req  input  1  level request to enter sleep (SLEEP instruction executed).
- wake  input  1  wake event (interrupt/WDT).
- q_phase  output  2  current phase: 0=Q1, 1=Q2, 2=Q3, 3=Q4.
- decode_en  output  1  Q1 strobe.
- data_rd_en  output  1  Q2 strobe.
- exec_en  output  1  Q3 strobe (ALU evaluate).
- wr_en  output  1  Q4 strobe (W/file/status write).
- instr_rd_en  output  1  Q4 strobe; latches the fetched instruction into the instruction register.
- incr_pc_en  output  1  Q4 strobe; PC <= PC+1.
- pc_load_en  output  1  Q4 strobe; PC <= branch target.
- nop_force  output  1  current instruction cycle is a forced NOP.
- sleeping  output  1  sequencer is in SLEEP.
- instr_count  output  INSTR_CNT_W  count of retired non-forced instruction cycles.

Behaviour:
- States: STARTUP, RUN, FLUSH, SLEEP. Phase counter is 2 bits and wraps 3->0.
- Reset (rst_n=0 at a clock edge): state=STARTUP, q_phase=0, NOP-cycle counter=0, instr_count=0. All strobes are 0 during the reset clock. rst_n overrides hold.
- Strobe decoding:
  - Strobes are decoded from the registered phase/state; only pc_load_en and incr_pc_en also depend on branch_taken in the same clock.
  - RUN: decode_en=Q1, data_rd_en=Q2, exec_en=Q3, wr_en=Q4, instr_rd_en=Q4.
  - pc_load_en = Q4 & branch_taken. incr_pc_en = Q4 & ~branch_taken.
  - STARTUP/FLUSH: nop_force=1; decode_en, data_rd_en, exec_en, wr_en and pc_load_en are held 0; instr_rd_en=Q4; incr_pc_en=Q4. branch_taken is ignored.
  - SLEEP: all strobes 0, nop_force=0, sleeping=1, q_phase held at 0.
- hold=1: phase, state, NOP counter and instr_count are frozen; every strobe output is 0. Inputs sampled at a held edge are ignored. Resumes at the same phase when hold drops.
- Transitions (at the Q4 edge, hold=0):
  - STARTUP: increment NOP counter; when it reaches STARTUP_NOPS, go to RUN.
  - RUN:
    - branch_taken -> FLUSH; instr_count+1.
    - else sleep_req -> SLEEP; instr_count+1.
    - else stay in RUN; instr_count+1.
    - branch_taken has priority over sleep_req.
  - FLUSH: -> RUN, or -> SLEEP if sleep_req is still high. instr_count unchanged.
- SLEEP: the first edge with wake=1 -> RUN at Q1. wake and sleep_req both high -> wake wins. wake outside SLEEP is ignored.
- Cycle cost: normal instruction 4 clocks; taken branch 8 clocks (4 + 4-clock FLUSH).
- instr_count wraps modulo 2^INSTR_CNT_W.

Test Plan:
- Reset with STARTUP_NOPS=1, then release with no events -> clocks 0-3 nop_force=1 with instr_rd_en and incr_pc_en pulsed at clock 3. From clock 4, q_phase cycles 0,1,2,3 with decode/rd/exec/wr one-hot. instr_count=2 after clock 11.
- branch_taken=1 during Q4 of the 2nd RUN cycle -> pc_load_en=1 and incr_pc_en=0 that clock. The next 4 clocks have nop_force=1 and wr_en=0. instr_count is unchanged across the flush; the next RUN Q1 follows 8 clocks after the branch cycle's Q1.
- branch_taken and sleep_req both high at Q4 -> FLUSH first, then SLEEP after the flush Q4 (sleep_req still high). sleeping=1 and all strobes 0. Assert wake for 1 clock -> next clock q_phase=0 in RUN with decode_en=1.
- hold=1 for 5 clocks starting at Q2 -> q_phase stays 1 and all strobes are 0. After release, data_rd_en=1 on the first clock and the sequence continues Q3, Q4.
- INSTR_CNT_W=4, run 17 instructions -> instr_count wraps to 1.
- rst_n=0 asserted mid-FLUSH at Q2 -> next clock state=STARTUP, q_phase=0, instr_count=0, strobes 0. Repeat the same check with hold=1 to confirm reset dominates.
